io_terminal_emu: RTL and testbench
==================================

// Module: io_terminal_emu
// PURPOSE
//   Synthesizable terminal emulator for the Mano machine's character I/O. It replaces the
//   fixed fgiset/fgoset/inpr drive with queued, handshaked input and output. Host-pushed
//   characters go to the core via INPR/FGI; characters the core writes to OUTR come back
//   through an output FIFO. It sits beside the core in the sim/board top and adds a
//   programmable start-up hold, inter-character gap and printer latency.
// PARAMETERS
//   DATA_W      8   character width (INPR/OUTR/host data)
//   IN_DEPTH    16  input FIFO entries (power of 2, >=2)
//   OUT_DEPTH   16  output FIFO entries (power of 2, >=2)
//   START_DLY   10  cycles after reset release before any flag activity (>=1)
//   TX_GAP      4   idle cycles between consecutive input characters (>=0)
//   OUT_LAT     3   cycles from OUTR capture to the next fgoset pulse (>=1)
// PORTS
//   io_clock        in   1       system clock, rising edge
//   io_reset_n      in   1       asynchronous active-low reset
//   host_in_valid   in   1       host offers an input character
//   host_in_data    in   DATA_W  input character
//   host_in_ready   out  1       input FIFO not full; push on valid&ready
//   host_out_valid  out  1       output FIFO not empty
//   host_out_data   out  DATA_W  output FIFO head
//   host_out_ready  in   1       pop on valid&ready
//   cpu_fgi         in   1       core FGI flag state
//   cpu_fgo         in   1       core FGO flag state
//   cpu_outr        in   DATA_W  core OUTR register
//   io_fgiset       out  1       one-cycle pulse: set core FGI
//   io_fgoset       out  1       one-cycle pulse: set core FGO
//   io_inpr         out  DATA_W  character presented to core INPR
//   start_done      out  1       start-up hold complete
//   overrun         out  1       sticky: output char dropped, FIFO full
// BEHAVIOUR
// - Reset (async, io_reset_n=0): all outputs 0, FIFOs empty, FSMs idle, counters cleared.
// - Start: counter runs START_DLY cycles after release; start_done=1 thereafter.
//   No fgiset/fgoset before start_done. Host push is allowed during start-up.
// - In FIFO: host_in_ready = (count<IN_DEPTH), registered. Push+pop in one cycle keeps
//   count. Pointers wrap modulo IN_DEPTH.
// - Input FSM IN_IDLE->IN_LOAD->IN_SET->IN_WAIT_HI->IN_WAIT_LO->IN_GAP->IN_IDLE:
//   IDLE: leave when start_done & FIFO non-empty & cpu_fgi=0.
//   LOAD: io_inpr<=head, pop (1 cycle).
//   SET: io_fgiset=1 for exactly 1 cycle.
//   WAIT_HI: wait for cpu_fgi=1. WAIT_LO: wait for cpu_fgi=0 (core executed INP).
//   GAP: TX_GAP cycles; TX_GAP=0 goes straight to IDLE.
//   io_inpr holds the last loaded value between characters.
//   Latency: FIFO non-empty to fgiset is 2 cycles minimum.
// - Output FSM OUT_READY->OUT_ARMED->OUT_BUSY->OUT_READY:
//   READY: when start_done, io_fgoset=1 for 1 cycle -> ARMED.
//   ARMED: track cpu_fgo with a registered copy. A 1->0 transition means the core ran OUT.
//   On that cycle cpu_outr is captured into the out FIFO -> BUSY.
//   If the FIFO is full, the char is dropped and overrun<=1, sticky until reset.
//   BUSY: OUT_LAT cycles -> READY.
//   A cpu_fgo falling edge outside ARMED is ignored.
// - Out FIFO: host_out_data is the head, valid while non-empty. A capture on the same cycle
//   as a host pop is accepted even when the FIFO is full.
// - Reset mid-operation aborts both FSMs and discards FIFO contents; the start hold reruns.
// TESTING
// - Reset, START_DLY=10 -> start_done rises 10 cycles after release, fgoset pulses next
//   cycle, no fgiset.
// - Push 'A' (8'h41) with cpu_fgi=0 -> io_inpr=8'h41, one-cycle fgiset. Raise then drop
//   cpu_fgi -> 4 gap cycles, then the next char.
// - Push 3 chars back-to-back, host_in_ready low after IN_DEPTH pushes -> delivered in
//   order, one fgiset each, no loss.
// - cpu_outr=8'h5A, cpu_fgo 1->0 -> host_out_data=8'h5A valid next cycle. fgoset pulses
//   OUT_LAT cycles after capture.
// - Fill out FIFO (host_out_ready=0), one more OUT -> char dropped, overrun=1 and stays set.
// - Assert io_reset_n=0 while in IN_WAIT_LO with FIFO data -> outputs 0 immediately, FIFO
//   empty, start hold restarts.

Source files
------------

// File: rtl/io_terminal_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_terminal_if : host-side and core-side signal bundle for io_terminal_emu (rev 1.0)
// ----------------------------------------------------------------------------
interface io_terminal_if #(
  parameter int DATA_W = 8
);
  logic              host_in_valid;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_ready;
  logic              host_out_valid;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_ready;
  logic              cpu_fgi;
  logic              cpu_fgo;
  logic [DATA_W-1:0] cpu_outr;
  logic              io_fgiset;
  logic              io_fgoset;
  logic [DATA_W-1:0] io_inpr;
  logic              start_done;
  logic              overrun;

  modport slave (
    input  host_in_valid, host_in_data, host_out_ready, cpu_fgi, cpu_fgo, cpu_outr,
    output host_in_ready, host_out_valid, host_out_data, io_fgiset, io_fgoset, io_inpr,
           start_done, overrun
  );

  modport master (
    output host_in_valid, host_in_data, host_out_ready, cpu_fgi, cpu_fgo, cpu_outr,
    input  host_in_ready, host_out_valid, host_out_data, io_fgiset, io_fgoset, io_inpr,
           start_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/io_terminal_emu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_terminal_emu : queued, handshaked character I/O for the Mano core (rev 1.0)
// ----------------------------------------------------------------------------
module io_terminal_emu #(
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int START_DLY = 10,
  parameter int TX_GAP    = 4,
  parameter int OUT_LAT   = 3
) (
  input wire           io_clock,
  input wire           io_reset_n,
  io_terminal_if.slave bus
);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int SW     = $clog2(START_DLY + 1);
  localparam int GW     = $clog2(TX_GAP + 2);
  localparam int LW     = $clog2(OUT_LAT + 1);

  localparam logic [IN_AW:0]  IN_FULL    = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL   = (OUT_AW + 1)'(OUT_DEPTH);
  localparam logic [SW-1:0]   START_LAST = SW'(START_DLY - 1);
  localparam logic [GW-1:0]   GAP_LAST   = GW'(TX_GAP - 1);
  localparam logic [LW-1:0]   LAT_LAST   = LW'(OUT_LAT - 1);

  localparam logic [2:0] IN_IDLE    = 3'd0;
  localparam logic [2:0] IN_LOAD    = 3'd1;
  localparam logic [2:0] IN_SET     = 3'd2;
  localparam logic [2:0] IN_WAIT_HI = 3'd3;
  localparam logic [2:0] IN_WAIT_LO = 3'd4;
  localparam logic [2:0] IN_GAP     = 3'd5;

  localparam logic [1:0] OUT_READY  = 2'd0;
  localparam logic [1:0] OUT_ARMED  = 2'd1;
  localparam logic [1:0] OUT_BUSY   = 2'd2;

  logic [SW-1:0]     start_cnt_q, start_cnt_d;
  logic              start_done_q, start_done_d;
  logic [DATA_W-1:0] in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IN_AW:0]    in_cnt_q, in_cnt_d;
  logic              in_rdy_q, in_rdy_d;
  logic [2:0]        in_state_q, in_state_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_AW:0]   out_cnt_q, out_cnt_d;
  logic [1:0]        out_state_q, out_state_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic              fgo_prev_q, fgo_prev_d;
  logic              fgoset_q, fgoset_d;
  logic              overrun_q, overrun_d;
  logic              in_push, in_pop, out_pop, out_cap, out_wr;

  always_comb begin
    start_cnt_d  = start_cnt_q;
    start_done_d = start_done_q;
    if (!start_done_q) begin
      if (start_cnt_q == START_LAST) start_done_d = 1'b1;
      else                           start_cnt_d  = start_cnt_q + SW'(1);
    end

    in_push    = bus.host_in_valid & in_rdy_q;
    in_pop     = (in_state_q == IN_LOAD);
    in_state_d = in_state_q;
    gap_cnt_d  = gap_cnt_q;
    inpr_d     = inpr_q;
    case (in_state_q)
      IN_IDLE:    if (start_done_q && in_cnt_q != '0 && !bus.cpu_fgi) in_state_d = IN_LOAD;
      IN_LOAD: begin
        inpr_d     = in_mem_q[in_rd_q];
        in_state_d = IN_SET;
      end
      IN_SET:     in_state_d = IN_WAIT_HI;
      IN_WAIT_HI: if (bus.cpu_fgi) in_state_d = IN_WAIT_LO;
      IN_WAIT_LO: if (!bus.cpu_fgi) begin
        gap_cnt_d  = '0;
        in_state_d = (TX_GAP == 0) ? IN_IDLE : IN_GAP;
      end
      IN_GAP: begin
        if (gap_cnt_q == GAP_LAST) in_state_d = IN_IDLE;
        else                       gap_cnt_d  = gap_cnt_q + GW'(1);
      end
      default:    in_state_d = IN_IDLE;
    endcase
    in_wr_d  = in_push ? in_wr_q + IN_AW'(1) : in_wr_q;
    in_rd_d  = in_pop  ? in_rd_q + IN_AW'(1) : in_rd_q;
    in_cnt_d = in_cnt_q + (IN_AW + 1)'(in_push) - (IN_AW + 1)'(in_pop);
    in_rdy_d = (in_cnt_d < IN_FULL);

    // fgo_prev_q always follows the core flag; only ARMED acts on its falling edge.
    fgo_prev_d  = bus.cpu_fgo;
    out_pop     = (out_cnt_q != '0) & bus.host_out_ready;
    out_cap     = 1'b0;
    fgoset_d    = 1'b0;
    overrun_d   = overrun_q;
    out_state_d = out_state_q;
    lat_cnt_d   = lat_cnt_q;
    case (out_state_q)
      OUT_READY: if (start_done_q) begin
        fgoset_d    = 1'b1;
        out_state_d = OUT_ARMED;
      end
      OUT_ARMED: if (fgo_prev_q && !bus.cpu_fgo) begin
        out_cap     = 1'b1;
        lat_cnt_d   = '0;
        out_state_d = OUT_BUSY;
      end
      OUT_BUSY: begin
        // Expiry issues the READY pulse itself so fgoset lands exactly OUT_LAT after capture.
        if (lat_cnt_q == LAT_LAST) begin
          fgoset_d    = 1'b1;
          out_state_d = OUT_ARMED;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default:   out_state_d = OUT_READY;
    endcase
    out_wr = out_cap & ((out_cnt_q != OUT_FULL) | out_pop);
    if (out_cap && !out_wr) overrun_d = 1'b1;
    out_wr_d  = out_wr  ? out_wr_q + OUT_AW'(1) : out_wr_q;
    out_rd_d  = out_pop ? out_rd_q + OUT_AW'(1) : out_rd_q;
    out_cnt_d = out_cnt_q + (OUT_AW + 1)'(out_wr) - (OUT_AW + 1)'(out_pop);
  end

  always_ff @(posedge io_clock) begin
    if (in_push) in_mem_q[in_wr_q]   <= bus.host_in_data;
    if (out_wr)  out_mem_q[out_wr_q] <= bus.cpu_outr;
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      start_cnt_q  <= '0;
      start_done_q <= 1'b0;
      in_wr_q      <= '0;
      in_rd_q      <= '0;
      in_cnt_q     <= '0;
      in_rdy_q     <= 1'b0;
      in_state_q   <= IN_IDLE;
      gap_cnt_q    <= '0;
      inpr_q       <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      out_cnt_q    <= '0;
      out_state_q  <= OUT_READY;
      lat_cnt_q    <= '0;
      fgo_prev_q   <= 1'b0;
      fgoset_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      start_cnt_q  <= start_cnt_d;
      start_done_q <= start_done_d;
      in_wr_q      <= in_wr_d;
      in_rd_q      <= in_rd_d;
      in_cnt_q     <= in_cnt_d;
      in_rdy_q     <= in_rdy_d;
      in_state_q   <= in_state_d;
      gap_cnt_q    <= gap_cnt_d;
      inpr_q       <= inpr_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      out_cnt_q    <= out_cnt_d;
      out_state_q  <= out_state_d;
      lat_cnt_q    <= lat_cnt_d;
      fgo_prev_q   <= fgo_prev_d;
      fgoset_q     <= fgoset_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.host_in_ready  = in_rdy_q;
  assign bus.host_out_valid = (out_cnt_q != '0);
  assign bus.host_out_data  = (out_cnt_q != '0) ? out_mem_q[out_rd_q] : '0;
  assign bus.io_fgiset      = (in_state_q == IN_SET);
  assign bus.io_fgoset      = fgoset_q;
  assign bus.io_inpr        = inpr_q;
  assign bus.start_done     = start_done_q;
  assign bus.overrun        = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_io_terminal_emu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_terminal_emu : directed sequence with random characters vs. queue models (rev 1.0)
// ----------------------------------------------------------------------------
module tb_io_terminal_emu;
  localparam int DATA_W    = 8;
  localparam int IN_DEPTH  = 16;
  localparam int OUT_DEPTH = 16;
  localparam int START_DLY = 10;
  localparam int TX_GAP    = 4;
  localparam int OUT_LAT   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] in_q [$];
  logic [DATA_W-1:0] out_q [$];
  logic              ovr_exp;

  io_terminal_if #(.DATA_W(DATA_W)) bus ();

  io_terminal_emu #(
    .DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
    .START_DLY(START_DLY), .TX_GAP(TX_GAP), .OUT_LAT(OUT_LAT)
  ) dut (
    .io_clock  (clk),
    .io_reset_n(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_start_done"}, bus.start_done, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_fgiset"}, bus.io_fgiset, 0);
    check({tag, "_fgoset"}, bus.io_fgoset, 0);
    check({tag, "_inpr"}, bus.io_inpr, 0);
    check({tag, "_in_ready"}, bus.host_in_ready, 0);
    check({tag, "_out_valid"}, bus.host_out_valid, 0);
    check({tag, "_out_data"}, bus.host_out_data, 0);
  endtask

  // Start hold: done after START_DLY edges, fgoset on the following edge only.
  task automatic startup();
    for (int i = 1; i <= START_DLY + 1; i++) begin
      tick();
      check("start_done", bus.start_done, (i >= START_DLY));
      check("fgiset_startup", bus.io_fgiset, 0);
      check("fgoset_startup", bus.io_fgoset, (i == START_DLY + 1));
    end
    tick();
    check("fgoset_one_cycle", bus.io_fgoset, 0);
    bus.cpu_fgo = 1'b1;
    tick();
  endtask

  // Core executes OUT: FGO falls with OUTR holding c.
  task automatic core_out(input logic [DATA_W-1:0] c, input bit pop_same);
    bus.cpu_outr       = c;
    bus.cpu_fgo        = 1'b0;
    bus.host_out_ready = pop_same;
    if (pop_same && out_q.size() != 0) begin
      check("pop_head", bus.host_out_data, out_q[0]);
      void'(out_q.pop_front());
    end
    if (out_q.size() < OUT_DEPTH) out_q.push_back(c);
    else                          ovr_exp = 1'b1;
    tick();
    bus.host_out_ready = 1'b0;
    check("out_valid", bus.host_out_valid, (out_q.size() != 0));
    if (out_q.size() != 0) check("out_head", bus.host_out_data, out_q[0]);
    check("overrun", bus.overrun, ovr_exp);
    check("fgoset_at_capture", bus.io_fgoset, 0);
    for (int i = 1; i <= OUT_LAT; i++) begin
      tick();
      check("fgoset_latency", bus.io_fgoset, (i == OUT_LAT));
    end
    bus.cpu_fgo = 1'b1;
    tick();
    check("fgoset_pulse_end", bus.io_fgoset, 0);
  endtask

  task automatic drain_out();
    bus.host_out_ready = 1'b1;
    while (out_q.size() != 0) begin
      check("out_valid_drain", bus.host_out_valid, 1);
      check("out_data", bus.host_out_data, out_q.pop_front());
      tick();
    end
    bus.host_out_ready = 1'b0;
    check("out_empty", bus.host_out_valid, 0);
  endtask

  // Core side of one input character: wait for fgiset, read INPR, run INP.
  task automatic core_inp();
    int n;
    n = 0;
    bus.cpu_fgi = 1'b0;
    while (bus.io_fgiset !== 1'b1 && n < TX_GAP + 8) begin
      tick();
      n++;
    end
    check("fgiset_seen", bus.io_fgiset, 1);
    check("inpr", bus.io_inpr, in_q.pop_front());
    tick();
    check("fgiset_one_cycle", bus.io_fgiset, 0);
    bus.cpu_fgi = 1'b1;
    tick();
    bus.cpu_fgi = 1'b0;
    tick();
  endtask

  initial begin
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] a_char;
    int n;
    bus.host_in_valid  = 1'b0;
    bus.host_in_data   = '0;
    bus.host_out_ready = 1'b0;
    bus.cpu_fgi        = 1'b0;
    bus.cpu_fgo        = 1'b0;
    bus.cpu_outr       = '0;
    ovr_exp            = 1'b0;
    a_char             = 8'h41;

    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;
    startup();
    check("in_ready_after_start", bus.host_in_ready, 1);

    // Output path: fixed 8'h5A, then a random character, then drain.
    core_out(8'h5A, 1'b0);
    core_out(DATA_W'($urandom), 1'b0);
    drain_out();

    // Input path: 'A' latency, then next character after the inter-character gap.
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = a_char;
    in_q.push_back(a_char);
    tick();
    bus.host_in_valid = 1'b0;
    check("fgiset_lat0", bus.io_fgiset, 0);
    tick();
    check("fgiset_lat1", bus.io_fgiset, 0);
    tick();
    check("fgiset_lat2", bus.io_fgiset, 1);
    check("inpr_A", bus.io_inpr, in_q.pop_front());
    tick();
    check("fgiset_pulse", bus.io_fgiset, 0);
    c = DATA_W'($urandom);
    bus.cpu_fgi       = 1'b1;
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = c;
    in_q.push_back(c);
    tick();
    bus.host_in_valid = 1'b0;
    bus.cpu_fgi       = 1'b0;
    for (int i = 1; i <= TX_GAP + 3; i++) begin
      tick();
      check("gap_timing", bus.io_fgiset, (i == TX_GAP + 3));
      if (i == 1) check("inpr_hold", bus.io_inpr, a_char);
    end
    check("inpr_next", bus.io_inpr, in_q.pop_front());
    tick();
    bus.cpu_fgi = 1'b1;
    tick();
    bus.cpu_fgi = 1'b0;
    tick();

    // Fill the input FIFO while the core holds FGI, then deliver everything in order.
    bus.cpu_fgi = 1'b1;
    repeat (TX_GAP + 2) tick();
    bus.host_in_valid = 1'b1;
    for (int i = 0; i < IN_DEPTH + 2; i++) begin
      c = DATA_W'($urandom);
      bus.host_in_data = c;
      check("in_ready_fill", bus.host_in_ready, (in_q.size() < IN_DEPTH));
      if (in_q.size() < IN_DEPTH) in_q.push_back(c);
      tick();
    end
    bus.host_in_valid = 1'b0;
    check("in_full", bus.host_in_ready, 0);
    while (in_q.size() != 0) core_inp();
    check("in_ready_after_drain", bus.host_in_ready, 1);

    // Fill the output FIFO, overflow by one, then capture while full with a same-cycle pop.
    for (int i = 0; i < OUT_DEPTH; i++) core_out(DATA_W'($urandom), 1'b0);
    core_out(DATA_W'($urandom), 1'b0);
    core_out(DATA_W'($urandom), 1'b1);
    drain_out();
    check("overrun_sticky", bus.overrun, 1);

    // Reset while the input FSM waits for FGI to drop with more input queued.
    core_out(DATA_W'($urandom), 1'b0);
    c = DATA_W'($urandom);
    in_q.push_back(c);
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = c;
    tick();
    c = DATA_W'($urandom);
    in_q.push_back(c);
    bus.host_in_data = c;
    tick();
    bus.host_in_valid = 1'b0;
    n = 0;
    while (bus.io_fgiset !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("mid_fgiset", bus.io_fgiset, 1);
    check("mid_inpr", bus.io_inpr, in_q.pop_front());
    tick();
    bus.cpu_fgi = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    in_q.delete();
    out_q.delete();
    ovr_exp     = 1'b0;
    bus.cpu_fgi = 1'b0;
    bus.cpu_fgo = 1'b0;
    tick();
    rst_n = 1'b1;
    startup();
    for (int i = 0; i < TX_GAP + 4; i++) begin
      check("no_stale_input", bus.io_fgiset, 0);
      check("no_stale_output", bus.host_out_valid, 0);
      tick();
    end
    c = DATA_W'($urandom);
    in_q.push_back(c);
    bus.host_in_valid = 1'b1;
    bus.host_in_data  = c;
    tick();
    bus.host_in_valid = 1'b0;
    core_inp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
